// File: rtl/universal_shift_register.sv
// rtl/universal_shift_register.sv - N-bit universal shift register with hold/shift/load, rotate and shift counter
module universal_shift_register #(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    parameter int               CNT_W     = 4
) (
    input  logic             CLK,
    input  logic             Clrn,
    input  logic             EN,
    input  logic [1:0]       S,
    input  logic             ROT,
    input  logic             SR_in,
    input  logic             SL_in,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] Qn,
    output logic             SO,
    output logic [CNT_W-1:0] SHCNT,
    output logic             EMPTY
);

    localparam logic [1:0] MODE_HOLD  = 2'b00;
    localparam logic [1:0] MODE_RIGHT = 2'b01;
    localparam logic [1:0] MODE_LEFT  = 2'b10;
    localparam logic [1:0] MODE_LOAD  = 2'b11;

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WIDTH);

    logic [WIDTH-1:0] q_next;
    logic             so_next;
    logic [CNT_W-1:0] cnt_next;
    logic [CNT_W-1:0] cnt_inc;
    logic             right_in;
    logic             left_in;

    // Rotate feeds the outgoing bit back in place of the serial input.
    assign right_in = ROT ? Q[0]       : SR_in;
    assign left_in  = ROT ? Q[WIDTH-1] : SL_in;
    assign cnt_inc  = (SHCNT == CNT_FULL) ? SHCNT : SHCNT + 1'b1;

    always_comb begin
        q_next   = Q;
        so_next  = SO;
        cnt_next = SHCNT;
        if (EN) begin
            case (S)
                MODE_RIGHT: begin
                    q_next   = {right_in, Q[WIDTH-1:1]};
                    so_next  = Q[0];
                    cnt_next = cnt_inc;
                end
                MODE_LEFT: begin
                    q_next   = {Q[WIDTH-2:0], left_in};
                    so_next  = Q[WIDTH-1];
                    cnt_next = cnt_inc;
                end
                MODE_LOAD: begin
                    q_next   = D;
                    so_next  = 1'b0;
                    cnt_next = '0;
                end
                MODE_HOLD: begin
                    q_next   = Q;
                    so_next  = SO;
                    cnt_next = SHCNT;
                end
                default: begin
                    q_next   = Q;
                    so_next  = SO;
                    cnt_next = SHCNT;
                end
            endcase
        end
    end

    always_ff @(posedge CLK or negedge Clrn) begin
        if (!Clrn) begin
            Q     <= RESET_VAL;
            SO    <= 1'b0;
            SHCNT <= '0;
        end else begin
            Q     <= q_next;
            SO    <= so_next;
            SHCNT <= cnt_next;
        end
    end

    assign Qn    = ~Q;
    assign EMPTY = (SHCNT == CNT_FULL);

endmodule

// File: tb/tb_universal_shift_register.sv
// tb/tb_universal_shift_register.sv - self-checking bench for universal_shift_register
module tb_universal_shift_register;

    localparam int W = 8;

    logic         CLK = 1'b0;
    logic         Clrn;
    logic         EN;
    logic [1:0]   S;
    logic         ROT;
    logic         SR_in;
    logic         SL_in;
    logic [W-1:0] D;
    logic [W-1:0] Q;
    logic [W-1:0] Qn;
    logic         SO;
    logic [3:0]   SHCNT;
    logic         EMPTY;

    int n_checks = 0;
    int n_fail   = 0;
    bit cmp_on   = 1'b0;

    int m_q;
    int m_so;
    int m_cnt;

    universal_shift_register #(.WIDTH(W), .RESET_VAL(8'h00), .CNT_W(4)) dut (
        .CLK(CLK), .Clrn(Clrn), .EN(EN), .S(S), .ROT(ROT),
        .SR_in(SR_in), .SL_in(SL_in), .D(D),
        .Q(Q), .Qn(Qn), .SO(SO), .SHCNT(SHCNT), .EMPTY(EMPTY)
    );

    always #5 CLK = ~CLK;

    // Reference model in plain integer arithmetic.
    always @(posedge CLK or negedge Clrn) begin
        if (!Clrn) begin
            m_q = 0; m_so = 0; m_cnt = 0;
        end else if (EN) begin
            if (S == 2'd3) begin
                m_q = int'(D); m_so = 0; m_cnt = 0;
            end else if (S == 2'd1) begin
                m_so = m_q % 2;
                m_q  = (m_q / 2) + (ROT ? m_so : int'(SR_in)) * 128;
                if (m_cnt < W) m_cnt = m_cnt + 1;
            end else if (S == 2'd2) begin
                m_so = m_q / 128;
                m_q  = ((m_q * 2) % 256) + (ROT ? m_so : int'(SL_in));
                if (m_cnt < W) m_cnt = m_cnt + 1;
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge CLK) begin
        if (cmp_on) begin
            check("model_q",     int'(Q),     m_q);
            check("model_qn",    int'(Qn),    255 - m_q);
            check("model_so",    int'(SO),    m_so);
            check("model_shcnt", int'(SHCNT), m_cnt);
            check("model_empty", int'(EMPTY), (m_cnt == W) ? 1 : 0);
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic en, input logic [1:0] s, input logic rot,
                         input logic sr, input logic sl, input logic [W-1:0] d);
        EN = en; S = s; ROT = rot; SR_in = sr; SL_in = sl; D = d;
    endtask

    initial begin
        Clrn = 1'b0;
        drive(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 8'h00);
        tick(); tick();
        Clrn = 1'b1;
        cmp_on = 1'b1;

        // 1: async reset mid-clock from a loaded value
        drive(1'b1, 2'b11, 1'b0, 1'b0, 1'b0, 8'hA5);
        tick();
        check("load_a5", int'(Q), 8'hA5);
        #2 Clrn = 1'b0;
        #1;
        check("rst_q",     int'(Q),     8'h00);
        check("rst_qn",    int'(Qn),    8'hFF);
        check("rst_shcnt", int'(SHCNT), 0);
        check("rst_so",    int'(SO),    0);
        check("rst_empty", int'(EMPTY), 0);
        #1 Clrn = 1'b1;

        // 2: load, hold, enable low
        drive(1'b1, 2'b11, 1'b0, 1'b0, 1'b0, 8'h96);
        tick();
        check("load_96", int'(Q), 8'h96);
        drive(1'b1, 2'b00, 1'b1, 1'b1, 1'b1, 8'h00);
        repeat (3) tick();
        check("hold_96", int'(Q), 8'h96);
        drive(1'b0, 2'b11, 1'b0, 1'b0, 1'b0, 8'h00);
        tick();
        check("en_low_96", int'(Q), 8'h96);
        drive(1'b0, 2'b01, 1'b0, 1'b1, 1'b0, 8'h00);
        tick();
        check("en_low_shift", int'(Q), 8'h96);

        // 3: shift right out, saturation
        drive(1'b1, 2'b11, 1'b0, 1'b0, 1'b0, 8'h81);
        tick();
        drive(1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 8; i++) begin
            tick();
            check("sr_so_seq", int'(SO), (i == 0 || i == 7) ? 1 : 0);
        end
        check("sr_q",     int'(Q),     8'h00);
        check("sr_shcnt", int'(SHCNT), 8);
        check("sr_empty", int'(EMPTY), 1);
        tick();
        check("sr_sat",       int'(SHCNT), 8);
        check("sr_sat_empty", int'(EMPTY), 1);

        // 4: shift left with serial input
        drive(1'b1, 2'b11, 1'b0, 1'b0, 1'b0, 8'h00);
        tick();
        check("load_clears_empty", int'(EMPTY), 0);
        drive(1'b1, 2'b10, 1'b0, 1'b0, 1'b1, 8'h00);
        repeat (3) tick();
        check("sl_q",     int'(Q),     8'h07);
        check("sl_shcnt", int'(SHCNT), 3);
        check("sl_empty", int'(EMPTY), 0);

        // 5: rotate both directions
        drive(1'b1, 2'b11, 1'b0, 1'b0, 1'b0, 8'h3C);
        tick();
        drive(1'b1, 2'b01, 1'b1, 1'b1, 1'b1, 8'h00);
        repeat (2) tick();
        check("rot_r_q", int'(Q), 8'h0F);
        drive(1'b1, 2'b10, 1'b1, 1'b0, 1'b0, 8'h00);
        tick();
        check("rot_l_1", int'(Q), 8'h1E);
        repeat (7) tick();
        check("rot_l_q",     int'(Q),     8'h0F);
        check("rot_l_shcnt", int'(SHCNT), 8);

        // 6: reset during shifting
        drive(1'b1, 2'b11, 1'b0, 1'b0, 1'b0, 8'hB7);
        tick();
        drive(1'b1, 2'b01, 1'b0, 1'b1, 1'b0, 8'h00);
        repeat (5) tick();
        check("mid_shcnt5", int'(SHCNT), 5);
        check("mid_q",      int'(Q),     8'hFD);
        #2 Clrn = 1'b0;
        #1;
        check("mid_rst_shcnt", int'(SHCNT), 0);
        check("mid_rst_q",     int'(Q),     8'h00);
        #1 Clrn = 1'b1;
        tick();
        check("post_rst_shcnt", int'(SHCNT), 1);
        check("post_rst_q",     int'(Q),     8'h80);

        tick();
        cmp_on = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
